pipe_stage_skid: RTL and testbench

//   Parametrised, generic inter-stage pipeline register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready inter-stage pipeline register with a 2-entry skid buffer.
// All outputs come from flops. in_ready depends on state alone, so there is no
// combinational path from in_* or out_ready to any output. Supports flush,
// hazard bubble insertion and a saturating stall counter.
module pipe_stage_skid #(
    parameter int              CTRL_W      = 21,
    parameter int              DATA_W      = 64,
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h8000_0000,
    parameter int              STALL_CNT_W = 16
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bubble,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [PC_W-1:0]        out_pc,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // The state value is the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [PC_W-1:0]   main_pc;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;

    logic              push;
    logic              pop;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;
    logic              clear_main_ctrl;
    logic [CTRL_W-1:0] in_ctrl_eff;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready    = (state != FULL);
    assign out_valid   = (state != EMPTY);
    assign occupancy   = state;
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign in_ctrl_eff = in_bubble ? '0 : in_ctrl;

    assign out_ctrl = main_ctrl;
    assign out_data = main_data;
    assign out_pc   = main_pc;

    // Next-state and register-load decode from the push/pop handshakes.
    always_comb begin
        state_next      = state;
        load_main_in    = 1'b0;
        load_main_skid  = 1'b0;
        load_skid_in    = 1'b0;
        clear_main_ctrl = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next   = HALF;
                    load_main_in = 1'b1;
                end
            end
            HALF: begin
                if (push && !pop) begin
                    state_next   = FULL;
                    load_skid_in = 1'b1;
                end else if (pop && !push) begin
                    // Going empty: drop control so nothing stale leaks downstream.
                    state_next      = EMPTY;
                    clear_main_ctrl = 1'b1;
                end else if (push && pop) begin
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next     = HALF;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_next      = EMPTY;
                clear_main_ctrl = 1'b1;
            end
        endcase
    end

    // Occupancy state register; flush empties the stage.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Main register drives out_*; flush only kills control, data/pc hold.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            main_ctrl <= '0;
            main_data <= '0;
            main_pc   <= RESET_PC;
        end else if (flush) begin
            main_ctrl <= '0;
        end else if (load_main_in) begin
            main_ctrl <= in_ctrl_eff;
            main_data <= in_data;
            main_pc   <= in_pc;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            main_pc   <= skid_pc;
        end else if (clear_main_ctrl) begin
            main_ctrl <= '0;
        end
    end

    // Skid register catches the entry accepted while the output is stalled.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_pc   <= RESET_PC;
        end else if (flush) begin
            skid_ctrl <= '0;
        end else if (load_skid_in) begin
            skid_ctrl <= in_ctrl_eff;
            skid_data <= in_data;
            skid_pc   <= in_pc;
        end
    end

    // Stall counter: cycles where an entry is offered but not taken.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vector table, hand-written corner
// sequences (stall saturation, reset while full) and a randomized run checked
// against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        sysclk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_bubble, out_valid, out_ready;
    logic [20:0] in_ctrl, out_ctrl;
    logic [63:0] in_data, out_data;
    logic [31:0] in_pc, out_pc;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    pipe_stage_skid #(
        .CTRL_W(21), .DATA_W(64), .PC_W(32), .RESET_PC(RPC), .STALL_CNT_W(4)
    ) dut (
        .sysclk(sysclk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic        f, v, b, r;
        logic [20:0] c;
        logic [63:0] d;
        logic [31:0] p;
        logic        ev, er;
        logic [1:0]  eo;
        logic [20:0] ec;
        logic [63:0] ed;
        logic [31:0] ep;
    } vec_t;

    typedef struct {
        logic [20:0] c;
        logic [63:0] d;
        logic [31:0] p;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];
    logic [63:0] m_last_d;
    logic [31:0] m_last_p;
    int          m_stall;

    function automatic vec_t mk(input logic f, v, b, r, input logic [20:0] c,
                                input logic [63:0] d, input logic [31:0] p,
                                input logic ev, er, input logic [1:0] eo,
                                input logic [20:0] ec, input logic [63:0] ed,
                                input logic [31:0] ep);
        vec_t t;
        t.f = f; t.v = v; t.b = b; t.r = r; t.c = c; t.d = d; t.p = p;
        t.ev = ev; t.er = er; t.eo = eo; t.ec = ec; t.ed = ed; t.ep = ep;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input logic f, v, b, r, input logic [20:0] c,
                         input logic [63:0] d, input logic [31:0] p);
        flush = f; in_valid = v; in_bubble = b; out_ready = r;
        in_ctrl = c; in_data = d; in_pc = p;
    endtask

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 21'h0, 64'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_last_d = 64'h0;
        m_last_p = RPC;
        m_stall  = 0;
    endtask

    // One clock of the reference model: a FIFO of capacity 2.
    task automatic model_step(input logic rst, f, v, b, r, input logic [20:0] c,
                              input logic [63:0] d, input logic [31:0] p);
        ent_t e;
        bit   can_push, can_pop;
        if (rst) begin
            model_reset();
            return;
        end
        if (mq.size() != 0) begin
            m_last_d = mq[0].d;
            m_last_p = mq[0].p;
        end
        if (mq.size() != 0 && !r && m_stall < 15) m_stall++;
        if (f) begin
            mq.delete();
        end else begin
            can_push = v && (mq.size() < 2);
            can_pop  = (mq.size() != 0) && r;
            if (can_pop) void'(mq.pop_front());
            if (can_push) begin
                e.c = b ? 21'h0 : c;
                e.d = d;
                e.p = p;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_check();
        bit ne;
        ne = (mq.size() != 0);
        chk("rnd_valid", 64'(out_valid), 64'(ne));
        chk("rnd_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("rnd_occ",   64'(occupancy), 64'(mq.size()));
        chk("rnd_ctrl",  64'(out_ctrl), ne ? 64'(mq[0].c) : 64'h0);
        chk("rnd_data",  out_data, ne ? mq[0].d : m_last_d);
        chk("rnd_pc",    64'(out_pc), ne ? 64'(mq[0].p) : 64'(m_last_p));
        chk("rnd_stall", 64'(stall_cnt), 64'(m_stall));
    endtask

    initial begin
        logic        rr, rf, rv, rb, ro;
        logic [20:0] rc;
        logic [63:0] rd;
        logic [31:0] rp;

        reset = 1'b0;
        drive(0, 0, 0, 0, 21'h0, 64'h0, 32'h0);
        @(negedge sysclk);
        do_reset();

        // Reset state
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_occ",   64'(occupancy), 64'h0);
        chk("rst_ctrl",  64'(out_ctrl), 64'h0);
        chk("rst_data",  out_data, 64'h0);
        chk("rst_pc",    64'(out_pc), 64'(RPC));
        chk("rst_stall", 64'(stall_cnt), 64'h0);

        // Streaming: ctrl 1..8 back to back, 1-cycle latency, occupancy 1
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, 0, 1, 21'(k), 64'h1000 + 64'(k), RPC + 32'(4 * k),
                              1, 1, 2'd1, 21'(k), 64'h1000 + 64'(k), RPC + 32'(4 * k)));
        vecs.push_back(mk(0, 0, 0, 1, 21'h0, 64'h0, 32'h0, 0, 1, 2'd0, 21'h0, 64'h1008, 32'h8000_0020));
        // Backpressure: A, B fill the stage, C waits upstream
        vecs.push_back(mk(0, 1, 0, 0, 21'h11, 64'hA, 32'h8000_0100, 1, 1, 2'd1, 21'h11, 64'hA, 32'h8000_0100));
        vecs.push_back(mk(0, 1, 0, 0, 21'h22, 64'hB, 32'h8000_0104, 1, 0, 2'd2, 21'h11, 64'hA, 32'h8000_0100));
        vecs.push_back(mk(0, 1, 0, 0, 21'h33, 64'hC, 32'h8000_0108, 1, 0, 2'd2, 21'h11, 64'hA, 32'h8000_0100));
        vecs.push_back(mk(0, 1, 0, 1, 21'h33, 64'hC, 32'h8000_0108, 1, 1, 2'd1, 21'h22, 64'hB, 32'h8000_0104));
        vecs.push_back(mk(0, 1, 0, 1, 21'h33, 64'hC, 32'h8000_0108, 1, 1, 2'd1, 21'h33, 64'hC, 32'h8000_0108));
        vecs.push_back(mk(0, 0, 0, 1, 21'h0, 64'h0, 32'h0, 0, 1, 2'd0, 21'h0, 64'hC, 32'h8000_0108));
        // Bubble: ctrl forced to NOP, data/pc kept
        vecs.push_back(mk(0, 1, 1, 0, 21'h1F0F0, 64'hABCD, 32'h8000_0010, 1, 1, 2'd1, 21'h0, 64'hABCD, 32'h8000_0010));
        vecs.push_back(mk(0, 0, 0, 1, 21'h0, 64'h0, 32'h0, 0, 1, 2'd0, 21'h0, 64'hABCD, 32'h8000_0010));
        // Flush while full with a simultaneous offer; the offer is dropped
        vecs.push_back(mk(0, 1, 0, 0, 21'h44, 64'hD, 32'h8000_0200, 1, 1, 2'd1, 21'h44, 64'hD, 32'h8000_0200));
        vecs.push_back(mk(0, 1, 0, 0, 21'h55, 64'hE, 32'h8000_0204, 1, 0, 2'd2, 21'h44, 64'hD, 32'h8000_0200));
        vecs.push_back(mk(1, 1, 0, 0, 21'h66, 64'hF, 32'h8000_0208, 0, 1, 2'd0, 21'h0, 64'hD, 32'h8000_0200));
        vecs.push_back(mk(0, 0, 0, 1, 21'h0, 64'h0, 32'h0, 0, 1, 2'd0, 21'h0, 64'hD, 32'h8000_0200));
        vecs.push_back(mk(0, 1, 0, 0, 21'h77, 64'h10, 32'h8000_0300, 1, 1, 2'd1, 21'h77, 64'h10, 32'h8000_0300));
        vecs.push_back(mk(0, 0, 0, 1, 21'h0, 64'h0, 32'h0, 0, 1, 2'd0, 21'h0, 64'h10, 32'h8000_0300));

        foreach (vecs[i]) begin
            drive(vecs[i].f, vecs[i].v, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].d, vecs[i].p);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vecs[i].er));
            chk($sformatf("vec%0d_occ", i),   64'(occupancy), 64'(vecs[i].eo));
            chk($sformatf("vec%0d_ctrl", i),  64'(out_ctrl),  64'(vecs[i].ec));
            chk($sformatf("vec%0d_data", i),  out_data,       vecs[i].ed);
            chk($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(vecs[i].ep));
        end

        // Stall counter saturation, survives flush, cleared by reset
        do_reset();
        drive(0, 1, 0, 0, 21'h5, 64'h5, 32'h8000_0050);
        tick();
        drive(0, 0, 0, 0, 21'h0, 64'h0, 32'h0);
        repeat (10) tick();
        chk("stall_10", 64'(stall_cnt), 64'd10);
        repeat (10) tick();
        chk("stall_sat", 64'(stall_cnt), 64'd15);
        drive(1, 0, 0, 0, 21'h0, 64'h0, 32'h0);
        tick();
        chk("stall_flush_occ", 64'(occupancy), 64'd0);
        chk("stall_after_flush", 64'(stall_cnt), 64'd15);
        drive(0, 0, 0, 0, 21'h0, 64'h0, 32'h0);
        tick();
        chk("stall_idle", 64'(stall_cnt), 64'd15);
        do_reset();
        chk("stall_reset", 64'(stall_cnt), 64'd0);

        // Reset while full, with flush and handshakes active
        drive(0, 1, 0, 0, 21'h61, 64'h61, 32'h8000_0400);
        tick();
        drive(0, 1, 0, 0, 21'h62, 64'h62, 32'h8000_0404);
        tick();
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        drive(1, 1, 0, 1, 21'h63, 64'h63, 32'h8000_0408);
        tick();
        reset = 1'b0;
        chk("rfull_valid", 64'(out_valid), 64'd0);
        chk("rfull_pc",    64'(out_pc), 64'(RPC));
        chk("rfull_data",  out_data, 64'h0);
        chk("rfull_ctrl",  64'(out_ctrl), 64'h0);
        chk("rfull_occ",   64'(occupancy), 64'd0);
        chk("rfull_ready", 64'(in_ready), 64'd1);
        chk("rfull_stall", 64'(stall_cnt), 64'd0);
        drive(0, 1, 0, 0, 21'h64, 64'h64, 32'h8000_0500);
        tick();
        chk("post_rst_ctrl", 64'(out_ctrl), 64'h64);
        chk("post_rst_data", out_data, 64'h64);
        chk("post_rst_occ",  64'(occupancy), 64'd1);
        drive(0, 0, 0, 1, 21'h0, 64'h0, 32'h0);
        tick();
        chk("post_rst_drain", 64'(out_valid), 64'd0);

        // Randomized run against the queue model
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            model_check();
            rr = ($urandom_range(0, 79) == 0);
            rf = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 9) < 7);
            rb = ($urandom_range(0, 5) == 0);
            ro = ($urandom_range(0, 9) < 5);
            rc = 21'($urandom);
            rd = {$urandom, $urandom};
            rp = $urandom;
            reset = rr;
            drive(rf, rv, rb, ro, rc, rd, rp);
            model_step(rr, rf, rv, rb, ro, rc, rd, rp);
            tick();
        end
        reset = 1'b0;
        model_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
